// File: rtl/axi_lat_slv.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lat_slv  (with companion package axi_lat_pkg)
//  Purpose  : AXI subordinate that answers every write with one B and every
//             read burst with len+1 R beats. Each response comes after a fixed,
//             parameterised latency. One write and one read may be outstanding.
//             The two paths run independently. Write data is discarded. Read
//             data is the constant READ_DATA. The response code is RESP_CODE.
//  Ports    : clk_i       in   clock, all logic on the rising edge
//             rst_ni      in   synchronous active-low reset
//             slv_req_i   in   AW/W/AR payload + valid, b_ready, r_ready
//             slv_resp_o  out  aw/w/ar_ready, B/R payload + valid (registered)
//  Revision : 1.0  initial release
// ============================================================================
package axi_lat_pkg;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;
endpackage

module axi_lat_slv #(
    parameter type                            req_t         = axi_lat_pkg::req_t,
    parameter type                            resp_t        = axi_lat_pkg::resp_t,
    parameter int unsigned                    WRITE_LATENCY = 1,
    parameter int unsigned                    READ_LATENCY  = 1,
    parameter logic [1:0]                     RESP_CODE     = 2'b00,
    parameter logic [axi_lat_pkg::DATA_W-1:0] READ_DATA     = '0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);
    import axi_lat_pkg::*;

    // Counter widths: wide enough to hold the latency value, never zero bits.
    localparam int unsigned c_wcnt_w = (WRITE_LATENCY < 1) ? 1 : $clog2(WRITE_LATENCY + 1);
    localparam int unsigned c_rcnt_w = (READ_LATENCY  < 1) ? 1 : $clog2(READ_LATENCY  + 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA}         r_state_t;

    w_state_t            r_w_state;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic                r_aw_ready;
    logic                r_w_ready;
    logic                r_b_valid;
    logic [ID_W-1:0]     r_b_id;
    logic [1:0]          r_b_resp;

    r_state_t            r_r_state;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic                r_ar_ready;
    logic                r_r_valid;
    logic [ID_W-1:0]     r_r_id;
    logic [7:0]          r_r_len;
    logic [7:0]          r_beat;
    logic                r_r_last;
    logic [1:0]          r_r_resp;
    logic [DATA_W-1:0]   r_r_data;

    // Only a subset of the request is used; the rest is folded here so that
    // the ignored fields (addr, burst, strb, atop, ...) read as intentional.
    logic w_unused;
    assign w_unused = ^slv_req_i;

    // ------------------------------------------------------------------ write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_w_state  <= W_IDLE;
            r_wcnt     <= '0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= '0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (slv_req_i.aw_valid) begin
                        r_b_id     <= slv_req_i.aw.id;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (slv_req_i.w_valid && slv_req_i.w.last) begin
                        r_w_ready <= 1'b0;
                        r_wcnt    <= c_wcnt_w'(WRITE_LATENCY);
                        if (WRITE_LATENCY == 0) begin
                            r_b_valid <= 1'b1;
                            r_b_resp  <= RESP_CODE;
                            r_w_state <= W_RESP;
                        end else begin
                            r_w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    // B rises WRITE_LATENCY+1 cycles after the last W beat.
                    if (r_wcnt == '0) begin
                        r_b_valid <= 1'b1;
                        r_b_resp  <= RESP_CODE;
                        r_w_state <= W_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (slv_req_i.b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_b_resp   <= '0;
                        r_aw_ready <= 1'b1;
                        r_w_state  <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_r_state  <= R_IDLE;
            r_rcnt     <= '0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_id     <= '0;
            r_r_len    <= '0;
            r_beat     <= '0;
            r_r_last   <= 1'b0;
            r_r_resp   <= '0;
            r_r_data   <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (slv_req_i.ar_valid) begin
                        r_r_id     <= slv_req_i.ar.id;
                        r_r_len    <= slv_req_i.ar.len;
                        r_beat     <= '0;
                        r_rcnt     <= c_rcnt_w'(READ_LATENCY);
                        r_ar_ready <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            r_r_valid <= 1'b1;
                            r_r_last  <= (slv_req_i.ar.len == 8'd0);
                            r_r_resp  <= RESP_CODE;
                            r_r_data  <= READ_DATA;
                            r_r_state <= R_DATA;
                        end else begin
                            r_r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == '0) begin
                        r_r_valid <= 1'b1;
                        r_r_last  <= (r_r_len == 8'd0);
                        r_r_resp  <= RESP_CODE;
                        r_r_data  <= READ_DATA;
                        r_r_state <= R_DATA;
                    end else begin
                        r_rcnt <= r_rcnt - 1'b1;
                    end
                end
                R_DATA: begin
                    if (slv_req_i.r_ready) begin
                        if (r_beat == r_r_len) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_r_resp   <= '0;
                            r_r_data   <= '0;
                            r_ar_ready <= 1'b1;
                            r_r_state  <= R_IDLE;
                        end else begin
                            // beat < len <= 255 here, so beat+1 cannot wrap.
                            r_beat   <= r_beat + 8'd1;
                            r_r_last <= ((r_beat + 8'd1) == r_r_len);
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    // Every output is a flop; valid and ready never see a combinational path.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = r_aw_ready;
        slv_resp_o.w_ready  = r_w_ready;
        slv_resp_o.b_valid  = r_b_valid;
        slv_resp_o.b.id     = r_b_id;
        slv_resp_o.b.resp   = r_b_resp;
        slv_resp_o.ar_ready = r_ar_ready;
        slv_resp_o.r_valid  = r_r_valid;
        slv_resp_o.r.id     = r_r_id;
        slv_resp_o.r.data   = r_r_data;
        slv_resp_o.r.resp   = r_r_resp;
        slv_resp_o.r.last   = r_r_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lat_slv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lat_slv
//  Purpose  : Self-checking bench for axi_lat_slv. It applies a table of write
//             and read transactions, then concurrent traffic and a reset
//             issued mid-burst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_lat_slv;
    import axi_lat_pkg::*;

    localparam int unsigned WL = 1;
    localparam int unsigned RL = 2;
    localparam logic [1:0]  RC = 2'b01;
    localparam logic [31:0] RD = 32'hDEADBEEF;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    req_t  req;
    resp_t rsp;

    logic        aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic [3:0]  aw_id, ar_id;
    logic [7:0]  aw_len, ar_len;
    logic [31:0] w_data;

    always #5 clk = ~clk;

    always_comb begin
        req          = '0;
        req.aw.id    = aw_id;
        req.aw.len   = aw_len;
        req.aw_valid = aw_valid;
        req.w.data   = w_data;
        req.w.strb   = 4'hF;
        req.w.last   = w_last;
        req.w_valid  = w_valid;
        req.b_ready  = b_ready;
        req.ar.id    = ar_id;
        req.ar.len   = ar_len;
        req.ar_valid = ar_valid;
        req.r_ready  = r_ready;
    end

    axi_lat_slv #(
        .req_t         (req_t),
        .resp_t        (resp_t),
        .WRITE_LATENCY (WL),
        .READ_LATENCY  (RL),
        .RESP_CODE     (RC),
        .READ_DATA     (RD)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (rsp)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_txn(input logic [3:0] id, input int nbeats, input int lead,
                             input int exp_lat);
        int  t;
        int  sent;
        logic hs;
        w_data  = 32'h1234_0000;
        w_last  = (nbeats == 1);
        w_valid = (lead > 0);
        for (int i = 0; i < lead; i++) begin
            step();
            chk("w_stall_before_aw", 64'(rsp.w_ready), 64'd0);
        end
        aw_id    = id;
        aw_len   = 8'(nbeats - 1);
        aw_valid = 1'b1;
        t = 0;
        while (!rsp.aw_ready && t < 20) begin
            step();
            t++;
        end
        chk("aw_ready_idle", 64'(rsp.aw_ready), 64'd1);
        chk("w_ready_in_aw_cycle", 64'(rsp.w_ready), 64'd0);
        step();
        aw_valid = 1'b0;
        chk("aw_ready_busy", 64'(rsp.aw_ready), 64'd0);
        chk("w_ready_after_aw", 64'(rsp.w_ready), 64'd1);
        w_valid = 1'b1;
        sent = 0;
        t = 0;
        while (sent < nbeats && t < 100) begin
            hs = rsp.w_ready;
            step();
            t++;
            if (hs) begin
                sent++;
                w_last = (sent == nbeats - 1);
                w_data = w_data + 32'd1;
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        chk("w_beats_accepted", 64'(sent), 64'(nbeats));
        chk("w_ready_after_last", 64'(rsp.w_ready), 64'd0);
        t = 0;
        while (!rsp.b_valid && t < 50) begin
            step();
            t++;
        end
        chk("b_latency", 64'(t), 64'(exp_lat));
        chk("b_id", 64'(rsp.b.id), 64'(id));
        chk("b_resp", 64'(rsp.b.resp), 64'(RC));
        chk("b_user", 64'(rsp.b.user), 64'd0);
        step();
        chk("b_hold_valid", 64'(rsp.b_valid), 64'd1);
        chk("b_hold_id", 64'(rsp.b.id), 64'(id));
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        chk("b_done", 64'(rsp.b_valid), 64'd0);
        chk("aw_ready_after_b", 64'(rsp.aw_ready), 64'd1);
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [7:0] len, input bit stall,
                            input int exp_lat, input int exp_beats);
        int   t;
        int   beats;
        logic rr;
        ar_id    = id;
        ar_len   = len;
        ar_valid = 1'b1;
        r_ready  = 1'b0;
        t = 0;
        while (!rsp.ar_ready && t < 20) begin
            step();
            t++;
        end
        chk("ar_ready_idle", 64'(rsp.ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
        chk("ar_ready_busy", 64'(rsp.ar_ready), 64'd0);
        t = 0;
        while (!rsp.r_valid && t < 50) begin
            step();
            t++;
        end
        chk("r_latency", 64'(t), 64'(exp_lat));
        beats = 0;
        t = 0;
        while (beats < exp_beats && t < 3000) begin
            chk("r_valid_held", 64'(rsp.r_valid), 64'd1);
            if (!rsp.r_valid) break;
            chk("r_id", 64'(rsp.r.id), 64'(id));
            chk("r_data", 64'(rsp.r.data), 64'(RD));
            chk("r_resp", 64'(rsp.r.resp), 64'(RC));
            chk("r_last", 64'(rsp.r.last), 64'(beats == exp_beats - 1));
            rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            r_ready = rr;
            step();
            t++;
            if (rr) beats++;
        end
        r_ready = 1'b0;
        chk("r_beats", 64'(beats), 64'(exp_beats));
        if (!stall) chk("r_consecutive_cycles", 64'(t), 64'(exp_beats));
        chk("r_valid_after_last", 64'(rsp.r_valid), 64'd0);
        chk("ar_ready_after_last", 64'(rsp.ar_ready), 64'd1);
    endtask

    typedef struct {
        bit         is_read;
        logic [3:0] id;
        logic [7:0] len;
        int         w_lead;
        bit         stall;
        int         exp_lat;
        int         exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t;
        // is_read, id, len, w_lead, stall, expected latency, expected beats
        vecs[0] = '{1'b0, 4'd3,  8'd0,   0, 1'b0, 2, 1};
        vecs[1] = '{1'b1, 4'd5,  8'd3,   0, 1'b0, 3, 4};
        vecs[2] = '{1'b1, 4'd9,  8'd7,   0, 1'b1, 3, 8};
        vecs[3] = '{1'b0, 4'hA,  8'd2,   5, 1'b0, 2, 3};
        vecs[4] = '{1'b1, 4'd0,  8'd0,   0, 1'b0, 3, 1};
        vecs[5] = '{1'b0, 4'hF,  8'd3,   0, 1'b0, 2, 4};
        vecs[6] = '{1'b1, 4'd2,  8'd255, 0, 1'b0, 3, 256};

        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; r_ready = 1'b0; aw_id = '0; ar_id = '0;
        aw_len = '0; ar_len = '0; w_data = '0;
        rst_n = 1'b0;
        step(); step(); step();

        chk("rst_aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("rst_w_ready", 64'(rsp.w_ready), 64'd0);
        chk("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("rst_b_payload", 64'(rsp.b), 64'd0);
        chk("rst_r_payload", 64'(rsp.r), 64'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            if (vecs[i].is_read)
                read_txn(vecs[i].id, vecs[i].len, vecs[i].stall, vecs[i].exp_lat, vecs[i].exp_beats);
            else
                write_txn(vecs[i].id, vecs[i].exp_beats, vecs[i].w_lead, vecs[i].exp_lat);
            step();
        end

        // Write and read started together; each keeps its own timing.
        fork
            write_txn(4'd7, 2, 0, 2);
            read_txn(4'd4, 8'd0, 1'b0, 3, 1);
        join
        step();

        // Reset while beat 2 of a 6-beat burst is on the bus.
        ar_id = 4'd6; ar_len = 8'd5; ar_valid = 1'b1;
        step();
        ar_valid = 1'b0;
        t = 0;
        while (!rsp.r_valid && t < 50) begin
            step();
            t++;
        end
        chk("rst_seq_r_latency", 64'(t), 64'd3);
        r_ready = 1'b1;
        step(); step();
        r_ready = 1'b0;
        chk("rst_seq_beat2_valid", 64'(rsp.r_valid), 64'd1);
        chk("rst_seq_beat2_last", 64'(rsp.r.last), 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("midrst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("midrst_r_payload", 64'(rsp.r), 64'd0);
        r_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_beats", 64'(rsp.r_valid), 64'd0);
        end
        r_ready = 1'b0;
        read_txn(4'd1, 8'd1, 1'b0, 3, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
